// File: rtl/hier_capture_pkg.sv
// ============================================================================
// Module      : hier_capture_pkg
// Description : Shared types and helpers for the hierarchical capture stage:
//               FSM state encoding, FIFO entry width and a saturating
//               increment helper.
// Config      : HIER_CAPTURE_PARITY_EN widens each FIFO entry to {j,k,j^k}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hier_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

`ifdef HIER_CAPTURE_PARITY_EN
    localparam int ENTRY_W = 3;
`else
    localparam int ENTRY_W = 2;
`endif

    // Counter widths up to 31 bits are carried in a 32-bit container so a
    // single helper serves every counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        logic [31:0] res;
        res = val;
        if (inc && (val != max_val)) begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hier_capture_fifo.sv
// ============================================================================
// Module      : hier_capture_fifo
// Description : Small synchronous FIFO with wrap-bit pointers. When empty the
//               head output holds the last entry popped.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clr_i           - synchronous flush (priority over push/pop)
//               push_i/push_data_i - write request and data
//               pop_i           - remove head (ignored when empty)
//               full_o/empty_o  - status
//               head_o          - head entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hier_capture_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [ENTRY_W-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q;
    logic [AW:0]        rd_ptr_q;
    logic [ENTRY_W-1:0] last_q;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign w_pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push_ok = push_i && (!full_o || w_pop_ok);

    assign head_o = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (!clr_i && w_push_ok &&
                             (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hier_capture_stage.sv
// ============================================================================
// Module      : hier_capture_stage
// Description : Capture stage downstream of the inverter/buffer/AND3 netlist.
//               Registers j/k, counts toggles while running, queues sampled
//               {j,k} pairs and hands them out over valid/ready.
// Ports       : clk, rst_n            - clock, async active-low reset
//               j, k, sample_en       - upstream data and capture request
//               clr                   - synchronous clear (not stage-1 regs)
//               out_valid/out_ready/out_data - consumer handshake, {j,k}
//               toggle_cnt_j/_k       - saturating transition counters
//               overflow              - sticky dropped-sample flag
//               out_parity/parity_err - only with HIER_CAPTURE_PARITY_EN
// Config      : HIER_CAPTURE_PARITY_EN adds per-entry parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hier_capture_stage
    import hier_capture_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             j,
    input  logic             k,
    input  logic             sample_en,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_data,
    output logic [CNT_W-1:0] toggle_cnt_j,
    output logic [CNT_W-1:0] toggle_cnt_k,
`ifdef HIER_CAPTURE_PARITY_EN
    output logic             out_parity,
    output logic             parity_err,
`endif
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         s1_jk_q;
    logic               s1_en_q;
    logic [1:0]         prev_jk_q, prev_jk_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_j_q, cnt_j_d;
    logic [CNT_W-1:0]   cnt_k_q, cnt_k_d;
    logic               overflow_q, overflow_d;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    // Stage 1 runs every edge and ignores clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_jk_q <= 2'b00;
            s1_en_q <= 1'b0;
        end else begin
            s1_jk_q <= {j, k};
            s1_en_q <= sample_en;
        end
    end

    // The sample that arms the FSM out of IDLE is queued as well, so every
    // registered request reaches the FIFO one edge after stage 1.
    assign w_push = s1_en_q && !clr;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        prev_jk_d  = prev_jk_q;
        cnt_j_d    = cnt_j_q;
        cnt_k_d    = cnt_k_q;
        overflow_d = overflow_q;
        if (clr) begin
            state_d    = IDLE;
            cnt_j_d    = '0;
            cnt_k_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s1_en_q) state_d = ARMED;
                end
                ARMED: begin
                    prev_jk_d = s1_jk_q;
                    state_d   = s1_en_q ? RUN : IDLE;
                end
                RUN: begin
                    cnt_j_d   = CNT_W'(sat_inc(32'(cnt_j_q), 32'(CNT_MAX),
                                               s1_jk_q[1] ^ prev_jk_q[1]));
                    cnt_k_d   = CNT_W'(sat_inc(32'(cnt_k_q), 32'(CNT_MAX),
                                               s1_jk_q[0] ^ prev_jk_q[0]));
                    prev_jk_d = s1_jk_q;
                    if (!s1_en_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (w_push && w_full && !w_pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_jk_q  <= 2'b00;
            cnt_j_q    <= '0;
            cnt_k_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_jk_q  <= prev_jk_d;
            cnt_j_q    <= cnt_j_d;
            cnt_k_q    <= cnt_k_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef HIER_CAPTURE_PARITY_EN
    logic parity_err_q, parity_err_d;

    assign w_entry  = {s1_jk_q, ^s1_jk_q};
    assign out_data = w_head[2:1];
    assign out_parity = w_head[0];
    assign parity_err = parity_err_q;

    always_comb begin
        parity_err_d = parity_err_q;
        if (clr) begin
            parity_err_d = 1'b0;
        end else if (w_pop && (w_head[0] != (w_head[2] ^ w_head[1]))) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`else
    assign w_entry  = s1_jk_q;
    assign out_data = w_head;
`endif

    hier_capture_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .push_i      (w_push),
        .push_data_i (w_entry),
        .pop_i       (w_pop),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

    assign out_valid    = !w_empty;
    assign toggle_cnt_j = cnt_j_q;
    assign toggle_cnt_k = cnt_k_q;
    assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_hier_capture_stage.sv
// ============================================================================
// Module      : tb_hier_capture_stage
// Description : Self-checking bench for hier_capture_stage. A behavioural
//               reference model tracks stage 1, FSM, counters, overflow and a
//               queue of expected FIFO entries; outputs are compared every
//               cycle shortly before the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hier_capture_stage;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             j = 1'b0;
    logic             k = 1'b0;
    logic             sample_en = 1'b0;
    logic             clr = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [1:0]       out_data;
    logic [CNT_W-1:0] toggle_cnt_j;
    logic [CNT_W-1:0] toggle_cnt_k;
    logic             overflow;
`ifdef HIER_CAPTURE_PARITY_EN
    logic             out_parity;
    logic             parity_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hier_capture_stage #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .j            (j),
        .k            (k),
        .sample_en    (sample_en),
        .clr          (clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .toggle_cnt_j (toggle_cnt_j),
        .toggle_cnt_k (toggle_cnt_k),
`ifdef HIER_CAPTURE_PARITY_EN
        .out_parity   (out_parity),
        .parity_err   (parity_err),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_s1_jk;
    logic       m_s1_en;
    logic [1:0] m_prev;
    int         m_state;
    int         m_cj;
    int         m_ck;
    logic       m_ovf;
    logic [1:0] sb_q[$];
    logic       m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1_jk = 2'b00;
            m_s1_en = 1'b0;
            m_prev  = 2'b00;
            m_state = 0;
            m_cj    = 0;
            m_ck    = 0;
            m_ovf   = 1'b0;
            sb_q.delete();
        end else begin
            m_pop = (sb_q.size() != 0) && out_ready;
            if (clr) begin
                sb_q.delete();
                m_cj    = 0;
                m_ck    = 0;
                m_ovf   = 1'b0;
                m_state = 0;
            end else begin
                if (m_pop) void'(sb_q.pop_front());
                if (m_s1_en) begin
                    if (sb_q.size() < DEPTH) sb_q.push_back(m_s1_jk);
                    else m_ovf = 1'b1;
                end
                case (m_state)
                    0: if (m_s1_en) m_state = 1;
                    1: begin
                        m_prev  = m_s1_jk;
                        m_state = m_s1_en ? 2 : 0;
                    end
                    default: begin
                        if ((m_s1_jk[1] != m_prev[1]) && (m_cj < CMAX)) m_cj++;
                        if ((m_s1_jk[0] != m_prev[0]) && (m_ck < CMAX)) m_ck++;
                        m_prev = m_s1_jk;
                        if (!m_s1_en) m_state = 0;
                    end
                endcase
            end
            m_s1_jk = {j, k};
            m_s1_en = sample_en;
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #4;
            check("valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
            if (sb_q.size() != 0) begin
                check("head", {30'd0, out_data}, {30'd0, sb_q[0]});
`ifdef HIER_CAPTURE_PARITY_EN
                check("parity", {31'd0, out_parity}, {31'd0, ^sb_q[0]});
`endif
            end
            check("cnt_j", {24'd0, toggle_cnt_j}, m_cj);
            check("cnt_k", {24'd0, toggle_cnt_k}, m_ck);
            check("ovf", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef HIER_CAPTURE_PARITY_EN
            check("parity_err", {31'd0, parity_err}, 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic en, input logic [1:0] jk, input logic rdy);
        @(negedge clk);
        sample_en = en;
        {j, k}    = jk;
        out_ready = rdy;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            j = ~j;
            k = ~k;
            sample_en = 1'b1;
            #1;
            check("rst_valid", {31'd0, out_valid}, 32'd0);
            check("rst_data", {30'd0, out_data}, 32'd0);
            check("rst_cnt_j", {24'd0, toggle_cnt_j}, 32'd0);
            check("rst_ovf", {31'd0, overflow}, 32'd0);
        end
        @(negedge clk);
        j = 1'b0; k = 1'b0; sample_en = 1'b0;
        rst_n = 1'b1;
        repeat (5) cyc(1'b0, 2'b00, 1'b0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_cnt_k", {24'd0, toggle_cnt_k}, 32'd0);

        // Basic capture and latency.
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        #1 check("lat_e0", {31'd0, out_valid}, 32'd0);
        cyc(1'b1, 2'b11, 1'b1);
        #1 check("lat_e1", {31'd0, out_valid}, 32'd1);
        check("lat_data", {30'd0, out_data}, 32'h2);
        repeat (6) cyc(1'b0, 2'b00, 1'b1);
        check("basic_cnt_j", {24'd0, toggle_cnt_j}, 32'd2);
        check("basic_cnt_k", {24'd0, toggle_cnt_k}, 32'd1);

        // Overflow: six requests into a four-entry FIFO with no consumer.
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'(i), 1'b0);
        repeat (2) cyc(1'b0, 2'b00, 1'b0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_head", {30'd0, out_data}, 32'd0);
        repeat (6) cyc(1'b0, 2'b00, 1'b1);
        check("ovf_drained", {31'd0, out_valid}, 32'd0);
        check("ovf_last", {30'd0, out_data}, 32'd3);
        do_clr();
        #1 check("clr_ovf", {31'd0, overflow}, 32'd0);

        // Full with simultaneous pop.
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'(3 - (i % 4)), 1'b0);
        cyc(1'b0, 2'b00, 1'b1);
        cyc(1'b0, 2'b00, 1'b0);
        #1 check("fp_ovf", {31'd0, overflow}, 32'd0);
        check("fp_head", {30'd0, out_data}, 32'd2);
        repeat (6) cyc(1'b0, 2'b00, 1'b1);

        // Saturation of the j counter, then clear while running.
        for (int i = 0; i < 300; i++) cyc(1'b1, {i[0], 1'b0}, 1'b1);
        #1 check("sat_cnt_j", {24'd0, toggle_cnt_j}, 32'd255);
        @(negedge clk);
        sample_en = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1 check("clr_cnt_j", {24'd0, toggle_cnt_j}, 32'd0);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) cyc(1'b0, 2'b00, 1'b1);
        check("clr_idle_cnt", {24'd0, toggle_cnt_j}, 32'd0);

        // Asynchronous reset with three entries queued.
        cyc(1'b1, 2'b01, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        repeat (2) cyc(1'b0, 2'b00, 1'b0);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {30'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);
        #1 check("post_rst_v0", {31'd0, out_valid}, 32'd0);
        cyc(1'b0, 2'b00, 1'b1);
        #1 check("post_rst_v1", {31'd0, out_valid}, 32'd1);
        check("post_rst_data", {30'd0, out_data}, 32'd2);
        cyc(1'b0, 2'b00, 1'b1);
        #1 check("post_rst_alone", {31'd0, out_valid}, 32'd0);
        repeat (3) cyc(1'b0, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
